// File: rtl/conv3x3_ctrl_if.sv
`timescale 1ns/1ps
// conv3x3_ctrl_if: control, weight-load, pixel-memory, MAC and result handshake
// signals of the 3x3 convolution controller, with controller (slave) and environment (master) views.
interface conv3x3_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic                start;
  logic                busy;
  logic                done;
  logic                wt_load_en;
  logic [7:0]          wt_load_data;
  logic                pix_rd_en;
  logic [ADDR_W-1:0]   pix_rd_addr;
  logic [7:0]          pix_rd_data;
  logic [71:0]         win_px;
  logic [71:0]         win_wt;
  logic signed [31:0]  mac_out;
  logic                out_valid;
  logic                out_ready;
  logic signed [31:0]  out_data;
  logic [7:0]          out_row;
  logic [7:0]          out_col;

  modport slave (
    input  start, wt_load_en, wt_load_data, pix_rd_data, mac_out, out_ready,
    output busy, done, pix_rd_en, pix_rd_addr, win_px, win_wt,
           out_valid, out_data, out_row, out_col
  );

  modport master (
    output start, wt_load_en, wt_load_data, pix_rd_data, mac_out, out_ready,
    input  busy, done, pix_rd_en, pix_rd_addr, win_px, win_wt,
           out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/conv3x3_ctrl.sv
`timescale 1ns/1ps
// conv3x3_ctrl: walks every 3x3 window of an IMG_W x IMG_H image, fetches its pixels,
// captures the external MAC result and hands it out. Define CONV_CTRL_RELU_EN to clamp negatives to 0.
module conv3x3_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  conv3x3_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, OUT, DONE} state_t;

  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);
  localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);

  state_t             state_q, state_d;
  logic [1:0]         kr_q, kr_d, kc_q, kc_d;
  logic [7:0]         row_q, row_d, col_q, col_d;
  logic [8:0][7:0]    px_q, px_d, wt_q, wt_d;
  logic signed [31:0] out_data_q, out_data_d;
  logic [7:0]         out_row_q, out_row_d, out_col_q, out_col_d;
  logic signed [31:0] mac_sel;

`ifdef CONV_CTRL_RELU_EN
  assign mac_sel = bus.mac_out[31] ? 32'sd0 : bus.mac_out;
`else
  assign mac_sel = bus.mac_out;
`endif

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    state_d    = state_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    row_d      = row_q;
    col_d      = col_q;
    px_d       = px_q;
    wt_d       = wt_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          row_d   = 8'd0;
          col_d   = 8'd0;
          kr_d    = 2'd0;
          kc_d    = 2'd0;
        end else if (bus.wt_load_en) begin
          wt_d = {bus.wt_load_data, wt_q[8:1]};
        end
      end
      FETCH: begin
        // Read data lags the strobe by one cycle, so the first fetch cycle has nothing to store.
        if (kr_q != 2'd0 || kc_q != 2'd0) px_d = {bus.pix_rd_data, px_q[8:1]};
        if (kc_q == 2'd2) begin
          kc_d = 2'd0;
          kr_d = kr_q + 2'd1;
        end else begin
          kc_d = kc_q + 2'd1;
        end
        if (kr_q == 2'd2 && kc_q == 2'd2) state_d = WAIT;
      end
      WAIT: begin
        px_d    = {bus.pix_rd_data, px_q[8:1]};
        state_d = MAC;
      end
      MAC: begin
        out_data_d = mac_sel;
        out_row_d  = row_q;
        out_col_d  = col_q;
        state_d    = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            kr_d    = 2'd0;
            kc_d    = 2'd0;
            if (col_q == LAST_COL) begin
              col_d = 8'd0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking updates only; px/wt are plain flops (not RAM), so they take the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kr_q       <= 2'd0;
      kc_q       <= 2'd0;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
      px_q       <= '0;
      wt_q       <= '0;
      out_data_q <= 32'sd0;
      out_row_q  <= 8'd0;
      out_col_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      row_q      <= row_d;
      col_q      <= col_d;
      px_q       <= px_d;
      wt_q       <= wt_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.out_valid   = (state_q == OUT);
  assign bus.pix_rd_en   = (state_q == FETCH);
  assign bus.pix_rd_addr = (state_q == FETCH)
                         ? ADDR_W'((32'(row_q) + 32'(kr_q)) * IMG_W + 32'(col_q) + 32'(kc_q))
                         : '0;
  assign bus.win_px      = px_q;
  assign bus.win_wt      = wt_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
`timescale 1ns/1ps
// tb_conv3x3_ctrl: scoreboard bench for conv3x3_ctrl on a 4x4 image with an external MAC
// and a one-cycle-latency pixel memory; expected results come from a direct convolution model.
module tb_conv3x3_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int AW = 4;

  typedef struct {
    int data;
    int row;
    int col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_ctrl_if #(.ADDR_W(AW)) bus ();

  conv3x3_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [7:0]  mem [W*H];
  int          cur_w [9];
  int          ready_mode = 0;
  int          stall_left = 0;
  int          mac;

  // External MAC: unsigned pixels times signed weights.
  always_comb begin
    mac = 0;
    for (int k = 0; k < 9; k++)
      mac += int'(bus.win_px[k*8 +: 8]) * int'($signed(bus.win_wt[k*8 +: 8]));
    bus.mac_out = mac;
  end

  always @(posedge clk)
    if (bus.pix_rd_en) bus.pix_rd_data <= mem[bus.pix_rd_addr];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int r, input int c);
    exp_t e;
    e.data = d; e.row = r; e.col = c;
    exp_q.push_back(e);
  endtask

  // Reference: straightforward valid convolution over the bench's memory image.
  task automatic push_model();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        int s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += int'(mem[(r + dr) * W + c + dc]) * cur_w[dr * 3 + dc];
`ifdef CONV_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        push_exp(s, r, c);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      bus.busy,        0);
    check({tag, "_done"},      bus.done,        0);
    check({tag, "_out_valid"}, bus.out_valid,   0);
    check({tag, "_rd_en"},     bus.pix_rd_en,   0);
    check({tag, "_rd_addr"},   bus.pix_rd_addr, 0);
    check({tag, "_out_data"},  bus.out_data,    0);
    check({tag, "_out_row"},   bus.out_row,     0);
    check({tag, "_out_col"},   bus.out_col,     0);
    check({tag, "_win_px"},    bus.win_px,      0);
    check({tag, "_win_wt"},    bus.win_wt,      0);
  endtask

  task automatic load_weights();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.wt_load_en   = 1'b1;
      bus.wt_load_data = 8'(cur_w[i]);
    end
    @(posedge clk); #1;
    bus.wt_load_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++)
      check_int("weight_load", int'($signed(bus.win_wt[i*8 +: 8])), cur_w[i]);
  endtask

  task automatic check_weights_kept();
    for (int i = 0; i < 9; i++)
      check_int("weight_kept", int'($signed(bus.win_wt[i*8 +: 8])), cur_w[i]);
  endtask

  task automatic run_frame(input bit meas_lat, input bit noise, input bit load_on_start);
    int lat;
    bit got;
    @(posedge clk); #1;
    bus.start = 1'b1;
    if (load_on_start) begin
      bus.wt_load_en   = 1'b1;
      bus.wt_load_data = 8'h5a;
    end
    @(posedge clk);
    lat = 1;
    #1;
    bus.start      = 1'b0;
    bus.wt_load_en = 1'b0;
    if (meas_lat) begin
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.out_valid) break;
        @(posedge clk);
        lat++;
      end
      check_int("first_valid_latency", lat, 12);
    end
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if (noise) begin
        bus.start        = 1'($urandom_range(0, 1));
        bus.wt_load_en   = 1'($urandom_range(0, 1));
        bus.wt_load_data = 8'($urandom);
      end
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    bus.start      = 1'b0;
    bus.wt_load_en = 1'b0;
    check("done_seen", got, 1);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    check_int("results_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Ready driver: always high, random, or held low for the first stall_left valid cycles.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0 && bus.out_valid) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks hold stability while stalled.
  initial begin
    bit   held = 1'b0;
    int   h_data, h_row, h_col;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !bus.out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check_int("hold_data", bus.out_data, h_data);
          check_int("hold_row",  int'(bus.out_row), h_row);
          check_int("hold_col",  int'(bus.out_col), h_col);
        end
        if (!bus.out_ready) begin
          check("stall_no_fetch", bus.pix_rd_en, 0);
          held   = 1'b1;
          h_data = bus.out_data;
          h_row  = int'(bus.out_row);
          h_col  = int'(bus.out_col);
        end else begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check_int("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_int("out_data", bus.out_data, e.data);
            check_int("out_row",  int'(bus.out_row), e.row);
            check_int("out_col",  int'(bus.out_col), e.col);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b0;
    bus.wt_load_en   = 1'b0;
    bus.wt_load_data = 8'h00;
    for (int i = 0; i < W * H; i++) mem[i] = 8'(i);

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Edge-detect weights over a flat image: every window sums to zero.
    cur_w = '{1, 0, -1, 1, 0, -1, 1, 0, -1};
    for (int i = 0; i < W * H; i++) mem[i] = 8'd1;
    load_weights();
    push_exp(0, 0, 0); push_exp(0, 0, 1); push_exp(0, 1, 0); push_exp(0, 1, 1);
    run_frame(1'b0, 1'b0, 1'b0);

    // All-ones weights over an address-valued image, with first-result latency.
    for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
    cur_w = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_weights();
    push_exp(45, 0, 0); push_exp(54, 0, 1); push_exp(81, 1, 0); push_exp(90, 1, 1);
    run_frame(1'b1, 1'b0, 1'b0);

    // Same frame with the first result back-pressured for 5 cycles.
    ready_mode = 2;
    stall_left = 5;
    push_exp(45, 0, 0); push_exp(54, 0, 1); push_exp(81, 1, 0); push_exp(90, 1, 1);
    run_frame(1'b0, 1'b0, 1'b0);
    ready_mode = 0;

    // Negative weights: clamped or passed through depending on the build.
    cur_w = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    load_weights();
`ifdef CONV_CTRL_RELU_EN
    push_exp(0, 0, 0); push_exp(0, 0, 1); push_exp(0, 1, 0); push_exp(0, 1, 1);
`else
    push_exp(-45, 0, 0); push_exp(-54, 0, 1); push_exp(-81, 1, 0); push_exp(-90, 1, 1);
`endif
    run_frame(1'b0, 1'b0, 1'b0);

    // Reset during the second window's fetch aborts the frame with no done pulse.
    cur_w = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_weights();
    push_exp(45, 0, 0); push_exp(54, 0, 1); push_exp(81, 1, 0); push_exp(90, 1, 1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 3 && bus.pix_rd_en) break;
    end
    check_int("reached_second_fetch", exp_q.size(), 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end
    load_weights();
    push_exp(45, 0, 0); push_exp(54, 0, 1); push_exp(81, 1, 0); push_exp(90, 1, 1);
    run_frame(1'b1, 1'b0, 1'b0);

    // start/wt_load_en noise while busy, plus a load strobe coincident with start.
    for (int i = 0; i < 9; i++) cur_w[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
    load_weights();
    push_model();
    run_frame(1'b0, 1'b1, 1'b1);
    check_weights_kept();

    // Random frames with random back-pressure.
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 9; i++) cur_w[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      load_weights();
      push_model();
      run_frame(1'b0, 1'b0, 1'b0);
      check_weights_kept();
    end
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_ctrl.md
CONV3X3_CTRL -- requirements
Module: conv3x3_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default 6, meaning pixel-memory address width, with IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  begin frame; busy  out  1  frame in progress; done  out  1  one-cycle end-of-frame pulse.
REQ-006 SHALL have ports: wt_load_en  in  1  weight shift strobe; wt_load_data  in  8  signed weight.
REQ-007 SHALL have ports: pix_rd_en  out  1  memory read strobe; pix_rd_addr  out  ADDR_W  read address; pix_rd_data  in  8  unsigned pixel, valid exactly 1 cycle after pix_rd_en.
REQ-008 SHALL have ports: win_px  out  72  pixels px0..px8 (px0 in bits 7:0); win_wt  out  72  signed weights wt0..wt8 (wt0 in bits 7:0); mac_out  in  32  signed combinational MAC result of win_px/win_wt.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  32  signed result; out_row  out  8; out_col  out  8  output coordinates.

Function
REQ-010 SHALL compute a valid (unpadded) 3x3 convolution producing (IMG_H-2)x(IMG_W-2) results in row-major order, out_row/out_col = top-left window pixel coordinate.
REQ-011 SHALL implement FSM states IDLE, FETCH, WAIT, MAC, OUT, DONE.
REQ-012 IDLE: on wt_load_en, shift wt_load_data into wt8 while wt(k) <= wt(k+1); after 9 strobes wt0 holds the first value loaded.
REQ-013 IDLE: start=1 moves to FETCH with row=col=0; start has priority over wt_load_en in the same cycle (load ignored).
REQ-014 FETCH: 9 cycles, k=0..8, pix_rd_en=1, pix_rd_addr=(row+k/3)*IMG_W+(col+k%3); pix_rd_data in cycle k+1 is stored as px(k).
REQ-015 WAIT: 1 cycle, pix_rd_en=0, stores px8 then goes to MAC.
REQ-016 MAC: 1 cycle, registers mac_out into out_data with out_row/out_col, goes to OUT.
REQ-017 OUT: out_valid=1 and out_data/out_row/out_col held stable until out_valid&&out_ready; on transfer advance col, wrapping to 0 and incrementing row at col=IMG_W-3; after row=IMG_H-3,col=IMG_W-3 go to DONE, else FETCH.
REQ-018 Minimum window period SHALL be 12 cycles (9 FETCH + WAIT + MAC + 1 OUT) with out_ready held high.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE; start and wt_load_en SHALL be ignored while busy.
REQ-021 Weights SHALL remain unchanged during a frame; win_wt driven continuously from weight registers.
REQ-022 pix_rd_en SHALL be 0 outside FETCH.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, busy=0, done=0, out_valid=0, pix_rd_en=0, pix_rd_addr=0, out_data=0, out_row=0, out_col=0, all px and wt registers 0.
REQ-024 Reset mid-frame SHALL abort the frame without done pulse; after release the block waits in IDLE for start.

Configuration
REQ-025 Macro CONV_CTRL_RELU_EN defined: MAC state SHALL store 0 when mac_out is negative, else mac_out.
REQ-026 Macro CONV_CTRL_RELU_EN undefined: MAC state SHALL store mac_out unmodified (signed, may be negative).

Verification (IMG_W=IMG_H=4, external mac model, memory pixel value = address)
REQ-027 Weights 1,0,-1,1,0,-1,1,0,-1, all pixels 1 -> four results of 0 at (0,0),(0,1),(1,0),(1,1), then done pulse.
REQ-028 Weights all 1 -> results 45, 54, 81, 90 in order; first out_valid 12 cycles after start accepted.
REQ-029 out_ready low 5 cycles during first result -> out_data=45 held stable, no FETCH reads issued until transfer.
REQ-030 Weights all -1, RELU_EN defined -> all results 0; undefined -> -45, -54, -81, -90.
REQ-031 rst asserted during FETCH of second window -> all outputs at reset values immediately, no done; new start reproduces REQ-028 sequence.
REQ-032 start and wt_load_en pulsed while busy -> ignored, frame results and weights unchanged.
